// File: rtl/trace_ctrl.sv
// Host-command parser and packet-channel arbiter for the RAM tracer.
// Define TRACE_CTRL_TIMEOUT_EN to compile in the ARG-state timeout counter.
module trace_ctrl #(
  parameter logic [15:0] CMD_TIMEOUT = 16'd48000
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_strobe,
  input  logic [1:0]  trace_type,
  input  logic [22:0] trace_payload,
  input  logic        trace_strobe,
  output logic [1:0]  packet_type,
  output logic [22:0] packet_payload,
  output logic        packet_strobe,
  output logic        trace_enable,
  output logic        trace_reads,
  output logic        turbo,
  output logic        cmd_error
);

  typedef enum logic {IDLE, ARG} state_t;

  localparam logic [7:0] OP_SET_FLAGS = 8'h01;
  localparam logic [7:0] OP_PING      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h03;

  state_t      state, state_next;
  logic [7:0]  opcode;
  logic        pending;
  logic [7:0]  pending_arg;
  logic        arg_take;
  logic        timeout_hit;
  logic        ping_accept;
  logic        emit_status;
  logic        enable_next, reads_next, turbo_next, error_next;

`ifdef TRACE_CTRL_TIMEOUT_EN
  logic [15:0] wait_count;

  // Held at zero outside ARG so the first ARG cycle always starts from 0.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset)
      wait_count <= 16'd0;
    else if (state == IDLE)
      wait_count <= 16'd0;
    else
      wait_count <= wait_count + 16'd1;
  end

  assign timeout_hit = (state == ARG) && !cmd_strobe &&
                       (wait_count == CMD_TIMEOUT - 16'd1);
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = CMD_TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge mclk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    arg_take   = 1'b0;
    case (state)
      IDLE: if (cmd_strobe) state_next = ARG;
      ARG: begin
        if (cmd_strobe) begin
          arg_take   = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset)
      opcode <= 8'h00;
    else if (state == IDLE && cmd_strobe)
      opcode <= cmd_data;
  end

  // A PING is only dropped when the single status slot is still occupied.
  always_comb begin
    enable_next = trace_enable;
    reads_next  = trace_reads;
    turbo_next  = turbo;
    error_next  = cmd_error;
    ping_accept = 1'b0;
    if (arg_take) begin
      case (opcode)
        OP_SET_FLAGS: begin
          enable_next = cmd_data[0];
          reads_next  = cmd_data[1];
          turbo_next  = cmd_data[2];
        end
        OP_PING: begin
          if (pending) error_next  = 1'b1;
          else         ping_accept = 1'b1;
        end
        OP_CLEAR: error_next = 1'b0;
        default:  error_next = 1'b1;
      endcase
    end
    if (timeout_hit) error_next = 1'b1;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      trace_enable <= 1'b0;
      trace_reads  <= 1'b1;
      turbo        <= 1'b0;
      cmd_error    <= 1'b0;
    end else begin
      trace_enable <= enable_next;
      trace_reads  <= reads_next;
      turbo        <= turbo_next;
      cmd_error    <= error_next;
    end
  end

  assign emit_status = pending && !trace_strobe;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      pending     <= 1'b0;
      pending_arg <= 8'h00;
    end else begin
      pending <= (pending && !emit_status) || ping_accept;
      if (ping_accept) pending_arg <= cmd_data;
    end
  end

  // Tracer always wins; status flags are sampled as the packet leaves.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      packet_strobe  <= 1'b0;
      packet_type    <= 2'b00;
      packet_payload <= 23'd0;
    end else if (trace_strobe) begin
      packet_strobe  <= 1'b1;
      packet_type    <= trace_type;
      packet_payload <= trace_payload;
    end else if (pending) begin
      packet_strobe  <= 1'b1;
      packet_type    <= 2'b11;
      packet_payload <= {cmd_error, turbo, trace_reads, trace_enable, 11'b0, pending_arg};
    end else begin
      packet_strobe  <= 1'b0;
      packet_type    <= 2'b00;
      packet_payload <= 23'd0;
    end
  end

endmodule

// File: tb/tb_trace_ctrl.sv
// Randomised self-checking bench for trace_ctrl against a behavioural model.
// Timeout behaviour is checked according to TRACE_CTRL_TIMEOUT_EN.
module tb_trace_ctrl;

  localparam logic [15:0] TO = 16'd16;

  logic        mclk = 1'b0;
  logic        reset;
  logic [7:0]  cmd_data;
  logic        cmd_strobe;
  logic [1:0]  trace_type;
  logic [22:0] trace_payload;
  logic        trace_strobe;
  logic [1:0]  packet_type;
  logic [22:0] packet_payload;
  logic        packet_strobe;
  logic        trace_enable, trace_reads, turbo, cmd_error;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_en, m_rd, m_turbo, m_err, m_in_arg, m_pend;
  logic [7:0]  m_op, m_parg;
  int          m_cnt;
  bit          m_pstb;
  logic [1:0]  m_ptype;
  logic [22:0] m_ppay;

  always #5 mclk = ~mclk;

  trace_ctrl #(.CMD_TIMEOUT(TO)) dut (
    .mclk(mclk), .reset(reset),
    .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
    .trace_type(trace_type), .trace_payload(trace_payload), .trace_strobe(trace_strobe),
    .packet_type(packet_type), .packet_payload(packet_payload), .packet_strobe(packet_strobe),
    .trace_enable(trace_enable), .trace_reads(trace_reads), .turbo(turbo),
    .cmd_error(cmd_error)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_en = 0; m_rd = 1; m_turbo = 0; m_err = 0;
    m_in_arg = 0; m_pend = 0; m_op = 8'h00; m_parg = 8'h00; m_cnt = 0;
    m_pstb = 0; m_ptype = 2'b00; m_ppay = 23'd0;
  endtask

  // One clock of the model: pre-edge state and inputs -> post-edge state.
  task automatic modelStep(input bit cs, input logic [7:0] cd, input bit ts,
                           input logic [1:0] tt, input logic [22:0] tp);
    bit old_pend;
    old_pend = m_pend;
    if (ts) begin
      m_pstb = 1; m_ptype = tt; m_ppay = tp;
    end else if (m_pend) begin
      m_pstb = 1; m_ptype = 2'b11;
      m_ppay = {m_err, m_turbo, m_rd, m_en, 11'b0, m_parg};
      m_pend = 0;
    end else begin
      m_pstb = 0; m_ptype = 2'b00; m_ppay = 23'd0;
    end
    if (!m_in_arg) begin
      if (cs) begin
        m_op = cd; m_in_arg = 1; m_cnt = 0;
      end
    end else if (cs) begin
      m_in_arg = 0;
      if (m_op == 8'h01) begin
        m_en = cd[0]; m_rd = cd[1]; m_turbo = cd[2];
      end else if (m_op == 8'h02) begin
        if (old_pend) m_err = 1;
        else begin m_pend = 1; m_parg = cd; end
      end else if (m_op == 8'h03) begin
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end else begin
`ifdef TRACE_CTRL_TIMEOUT_EN
      if (m_cnt == int'(TO) - 1) begin
        m_in_arg = 0; m_err = 1;
      end else
`endif
      m_cnt++;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".strobe"},  packet_strobe,  m_pstb);
    checkOutput({tag, ".type"},    packet_type,    m_ptype);
    checkOutput({tag, ".payload"}, packet_payload, m_ppay);
    checkOutput({tag, ".enable"},  trace_enable,   m_en);
    checkOutput({tag, ".reads"},   trace_reads,    m_rd);
    checkOutput({tag, ".turbo"},   turbo,          m_turbo);
    checkOutput({tag, ".error"},   cmd_error,      m_err);
  endtask

  task automatic applyStimulus(input bit cs, input logic [7:0] cd, input bit ts,
                               input logic [1:0] tt, input logic [22:0] tp);
    cmd_strobe = cs; cmd_data = cd;
    trace_strobe = ts; trace_type = tt; trace_payload = tp;
    modelStep(cs, cd, ts, tt, tp);
    @(posedge mclk);
    #1;
    checkAll("cyc");
  endtask

  task automatic sendCmd(input logic [7:0] op, input logic [7:0] arg);
    applyStimulus(1, op, 0, 2'b00, 23'd0);
    applyStimulus(1, arg, 0, 2'b00, 23'd0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 2'b00, 23'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".strobe"},  packet_strobe,  0);
    checkOutput({tag, ".type"},    packet_type,    0);
    checkOutput({tag, ".payload"}, packet_payload, 0);
    checkOutput({tag, ".enable"},  trace_enable,   0);
    checkOutput({tag, ".reads"},   trace_reads,    1);
    checkOutput({tag, ".turbo"},   turbo,          0);
    checkOutput({tag, ".error"},   cmd_error,      0);
  endtask

  initial begin
    reset = 1; cmd_strobe = 0; cmd_data = 0;
    trace_strobe = 0; trace_type = 0; trace_payload = 0;
    modelReset();
    repeat (3) @(posedge mclk);
    #1;
    checkResetValues("reset");
    reset = 0;

    // PING from reset flags
    sendCmd(8'h02, 8'hA5);
    checkOutput("ping.early", packet_strobe, 0);
    idleCycles(1);
    checkOutput("ping.strobe", packet_strobe, 1);
    checkOutput("ping.type", packet_type, 2'b11);
    checkOutput("ping.payload", packet_payload, 23'h1000A5);
    idleCycles(1);
    checkOutput("ping.once", packet_strobe, 0);

    // SET_FLAGS
    sendCmd(8'h01, 8'h05);
    checkOutput("flags.enable", trace_enable, 1);
    checkOutput("flags.reads", trace_reads, 0);
    checkOutput("flags.turbo", turbo, 1);
    checkOutput("flags.error", cmd_error, 0);
    sendCmd(8'h01, 8'h00);

    // PING under a 10-cycle trace burst
    applyStimulus(1, 8'h02, 0, 2'b00, 23'd0);
    for (int i = 0; i < 10; i++)
      applyStimulus(i == 0, 8'h3C, 1, 2'($urandom_range(0, 3)), 23'($urandom));
    idleCycles(1);
    checkOutput("burst.status", packet_strobe, 1);
    checkOutput("burst.type", packet_type, 2'b11);
    checkOutput("burst.arg", packet_payload[7:0], 8'h3C);
    idleCycles(1);

    // Bad opcode, CLEAR, then SET_FLAGS
    sendCmd(8'h07, 8'h00);
    checkOutput("badop.error", cmd_error, 1);
    sendCmd(8'h03, 8'h00);
    checkOutput("clear.error", cmd_error, 0);
    sendCmd(8'h01, 8'h03);
    checkOutput("after.enable", trace_enable, 1);
    checkOutput("after.reads", trace_reads, 1);

    // Back-to-back PINGs: second is dropped while the first is blocked
    applyStimulus(1, 8'h02, 1, 2'b01, 23'h12345);
    applyStimulus(1, 8'h11, 1, 2'b01, 23'h12346);
    applyStimulus(1, 8'h02, 1, 2'b01, 23'h12347);
    applyStimulus(1, 8'h22, 1, 2'b01, 23'h12348);
    idleCycles(3);
    sendCmd(8'h03, 8'h00);

    // Argument arriving in the last allowed cycle, then a full timeout
    applyStimulus(1, 8'h01, 0, 2'b00, 23'd0);
    idleCycles(int'(TO) - 1);
    applyStimulus(1, 8'h02, 0, 2'b00, 23'd0);
    idleCycles(2);
    applyStimulus(1, 8'h01, 0, 2'b00, 23'd0);
    idleCycles(20);
`ifdef TRACE_CTRL_TIMEOUT_EN
    checkOutput("timeout.error", cmd_error, 1);
    sendCmd(8'h01, 8'h01);
    checkOutput("timeout.enable", trace_enable, 1);
`else
    applyStimulus(1, 8'h01, 0, 2'b00, 23'd0);
    checkOutput("notimeout.enable", trace_enable, 1);
`endif
    sendCmd(8'h03, 8'h00);

    // Reset in the middle of a command and a pending status
    applyStimulus(1, 8'h02, 1, 2'b10, 23'h7FFFFF);
    applyStimulus(1, 8'h44, 1, 2'b10, 23'h000001);
    applyStimulus(1, 8'h01, 0, 2'b00, 23'd0);
    reset = 1;
    #1;
    checkResetValues("midreset");
    modelReset();
    @(posedge mclk);
    #1;
    reset = 0;
    sendCmd(8'h01, 8'h07);
    checkOutput("postreset.enable", trace_enable, 1);
    checkOutput("postreset.turbo", turbo, 1);
    idleCycles(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] cd;
      cd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      applyStimulus($urandom_range(0, 2) == 0, cd, $urandom_range(0, 1) == 1,
                    2'($urandom_range(0, 3)), 23'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
